pdm_decimator: RTL and testbench
================================

PDM_DECIMATOR -- requirements
Module: pdm_decimator

Interface
REQ-001 Parameter NBITS, default 10: PCM output width.
REQ-002 Parameter HALF_DIV, default 20: clk cycles per mic_clk half-period (100 MHz -> 2.5 MHz mic_clk).
REQ-003 Parameter DECIM, default 64: PDM bits per PCM sample, fixed power of two.
REQ-004 clk  in  1  system clock, 100 MHz.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 en  in  1  enable; high = mic_clk runs and samples are captured.
REQ-007 pdm_din  in  1  PDM data from microphone, asynchronous to clk.
REQ-008 mic_clk  out  1  clock to microphone, registered.
REQ-009 dout  out  NBITS  PCM sample, unsigned, 0 = all-zeros density, 1023 = full density.
REQ-010 dout_valid  out  1  one-clk strobe, dout updated in the same cycle.
REQ-011 clip  out  1  one-clk strobe with dout_valid when the sample saturated.

Function
REQ-012 pdm_din passes through a 2-flop synchronizer before any use.
REQ-013 Divider counter runs 0..HALF_DIV-1 while en=1; on terminal count it wraps to 0 and mic_clk toggles.
REQ-014 Sample strobe asserts for one clk in the cycle mic_clk is driven 0->1; the synchronized bit is captured then.
REQ-015 Each captured bit enters a 3-stage CIC (sinc3) as integer 0 or 1; integrator width W = 1 + 3*log2(DECIM) = 19 bits.
REQ-016 Integrators accumulate modulo 2^W; wrap-around is intended and not flagged.
REQ-017 Decimation counter counts captured bits 0..DECIM-1; on each wrap to 0 the last integrator output feeds 3 comb stages (differential delay 1).
REQ-018 Comb result range 0..DECIM^3 (0..262144); dout = min(result >> (W-1-NBITS), 2^NBITS-1), i.e. result>>8 saturated to 1023.
REQ-019 clip = 1 exactly when the unshifted saturation in REQ-018 takes effect.
REQ-020 dout_valid asserts at most 3 clk after the sample strobe of the DECIM-th bit; strobes spaced exactly DECIM*2*HALF_DIV clk apart in steady state.
REQ-021 dout holds its value between strobes.
REQ-022 en=0: mic_clk driven low within one clk, divider and decimation counters and CIC state hold, no strobes; en=1 resumes from held state.
REQ-023 Sample strobe and decimation wrap in the same cycle: the bit is included in the sample being emitted.

Reset
REQ-024 rst clears divider, decimation counter, synchronizer, all integrators and comb delays; mic_clk=0, dout=0, dout_valid=0, clip=0.
REQ-025 rst mid-operation discards any partial sample; no dout_valid in the reset cycle or the following cycle.
REQ-026 rst has priority over en.

Structure
REQ-027 NBITS default, CIC order (3) and width formula live in the shared package synth_pkg.
REQ-028 Integrator/comb chain is one sub-module cic_sinc3 (inputs: bit, sample strobe, decimate strobe; output: W-bit result, valid).
REQ-029 Divider, synchronizer, decimation counter and output scaling/saturation stay in pdm_decimator.

Verification
REQ-030 Constant pdm_din=1, en=1 from reset -> dout reaches 1023 no later than the 4th dout_valid and stays; clip=1 on those strobes.
REQ-031 Constant pdm_din=0 -> every dout_valid has dout=0, clip=0.
REQ-032 Alternating 1010... (50% density) -> settled dout=512 exactly, clip=0.
REQ-033 Loopback: reference PDM modulator (same codebase) driven with constant 256 via mic_clk-rate strobes -> settled dout within 256±2.
REQ-034 en dropped for 1000 clk mid-sample -> mic_clk low, no strobe; after re-enable next strobe arrives after exactly the remaining bits; value equals the non-paused run.
REQ-035 rst asserted mid-sample during all-ones input -> dout=0 immediately, next strobes ramp as in REQ-030; strobe period 2560 clk with defaults.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared constants and helpers for the audio front-end blocks.
// CIC order and integrator width rule live here so every decimator agrees.
package synth_pkg;

  localparam int unsigned NBITS_DEF = 10;
  localparam int unsigned CIC_ORDER = 3;

  typedef enum logic {
    MIC_LOW  = 1'b0,
    MIC_HIGH = 1'b1
  } mic_phase_e;

  // Bit growth of an N-stage CIC fed with a 1-bit input: 1 + N*log2(R).
  function automatic int unsigned cic_width(input int unsigned decim);
    return 1 + CIC_ORDER * $clog2(decim);
  endfunction

endpackage

// File: rtl/pdm_decimator_cic_sinc3.sv
// Third-order CIC (sinc3) for a 1-bit input, differential delay 1.
// Integrators run on every sample strobe; combs run once per decimation.
module cic_sinc3
  import synth_pkg::*;
#(
  parameter int unsigned DECIM = 64,
  parameter int unsigned W     = cic_width(DECIM)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_bit,
  input  logic         i_sample,
  input  logic         i_decimate,
  output logic [W-1:0] o_result,
  output logic         o_valid
);

  logic [W-1:0] r_int1, r_int2, r_int3;
  logic [W-1:0] w_int1, w_int2, w_int3;
  logic [W-1:0] r_dly1, r_dly2, r_dly3;
  logic [W-1:0] w_c1, w_c2, w_c3;
  logic [W-1:0] r_result;
  logic         r_valid;
  logic         r_dec_pend;

  // Integrators are chained combinationally so the bit captured on the
  // decimation strobe is already part of the sample handed to the combs.
  always_comb begin
    w_int1 = r_int1 + {{(W-1){1'b0}}, i_bit};
    w_int2 = r_int2 + w_int1;
    w_int3 = r_int3 + w_int2;
  end

  always_comb begin
    w_c1 = r_int3 - r_dly1;
    w_c2 = w_c1 - r_dly2;
    w_c3 = w_c2 - r_dly3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_int1     <= '0;
      r_int2     <= '0;
      r_int3     <= '0;
      r_dly1     <= '0;
      r_dly2     <= '0;
      r_dly3     <= '0;
      r_result   <= '0;
      r_valid    <= 1'b0;
      r_dec_pend <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      r_dec_pend <= i_sample & i_decimate;
      if (i_sample) begin
        r_int1 <= w_int1;
        r_int2 <= w_int2;
        r_int3 <= w_int3;
      end
      if (r_dec_pend) begin
        r_dly1   <= r_int3;
        r_dly2   <= w_c1;
        r_dly3   <= w_c2;
        r_result <= w_c3;
        r_valid  <= 1'b1;
      end
    end
  end

  assign o_result = r_result;
  assign o_valid  = r_valid;

endmodule

// File: rtl/pdm_decimator.sv
// PDM microphone front end: mic clock generation, input synchronizer,
// decimation counting and saturating scaling of the sinc3 output to PCM.
module pdm_decimator
  import synth_pkg::*;
#(
  parameter int unsigned NBITS    = NBITS_DEF,
  parameter int unsigned HALF_DIV = 20,
  parameter int unsigned DECIM    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pdm_din,
  output logic             mic_clk,
  output logic [NBITS-1:0] dout,
  output logic             dout_valid,
  output logic             clip
);

  localparam int unsigned W     = cic_width(DECIM);
  localparam int unsigned SHIFT = W - 1 - NBITS;
  localparam int unsigned DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int unsigned DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [1:0]       r_sync;
  logic [DIV_W-1:0] r_div;
  logic [DEC_W-1:0] r_dec;
  mic_phase_e       r_phase;
  mic_phase_e       w_phase_next;
  logic             r_mic;
  logic             w_tc;
  logic             w_sample;
  logic             w_decimate;

  logic [W-1:0]     w_result;
  logic             w_cic_valid;
  logic [W-1:0]     w_shifted;
  logic             w_sat;

  logic [NBITS-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_clip;

  always_comb begin
    w_tc         = en && (r_div == DIV_W'(HALF_DIV - 1));
    w_phase_next = r_phase;
    if (w_tc) begin
      w_phase_next = (r_phase == MIC_LOW) ? MIC_HIGH : MIC_LOW;
    end
    w_sample   = w_tc && (r_phase == MIC_LOW);
    w_decimate = w_sample && (r_dec == DEC_W'(DECIM - 1));
  end

  // The logical phase is held while disabled; only the pin is forced low,
  // so re-enabling continues the bit period exactly where it stopped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_div   <= '0;
      r_dec   <= '0;
      r_phase <= MIC_LOW;
      r_mic   <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], pdm_din};
      if (en) begin
        r_div   <= w_tc ? '0 : r_div + 1'b1;
        r_phase <= w_phase_next;
        r_mic   <= (w_phase_next == MIC_HIGH);
        if (w_sample) begin
          r_dec <= w_decimate ? '0 : r_dec + 1'b1;
        end
      end else begin
        r_mic <= 1'b0;
      end
    end
  end

  cic_sinc3 #(
    .DECIM (DECIM),
    .W     (W)
  ) u_cic (
    .clk        (clk),
    .rst        (rst),
    .i_bit      (r_sync[1]),
    .i_sample   (w_sample),
    .i_decimate (w_decimate),
    .o_result   (w_result),
    .o_valid    (w_cic_valid)
  );

  always_comb begin
    w_shifted = w_result >> SHIFT;
    w_sat     = |w_shifted[W-1:NBITS];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_clip       <= 1'b0;
    end else begin
      r_dout_valid <= w_cic_valid;
      r_clip       <= w_cic_valid & w_sat;
      if (w_cic_valid) begin
        r_dout <= w_sat ? '1 : w_shifted[NBITS-1:0];
      end
    end
  end

  assign mic_clk    = r_mic;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign clip       = r_clip;

endmodule

// File: tb/tb_pdm_decimator.sv
// Self-checking bench for pdm_decimator: bit-stream patterns with an FIR
// reference of the sinc3 response, plus pause and mid-sample reset cases.
`timescale 1ns/1ps
module tb_pdm_decimator;

  localparam int unsigned NB     = 10;
  localparam int unsigned HD     = 20;
  localparam int unsigned DC     = 64;
  localparam int          PERIOD = DC * 2 * HD;
  localparam int          HLEN   = 3 * DC - 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          pdm_din = 1'b0;
  logic          mic_clk;
  logic [NB-1:0] dout;
  logic          dout_valid;
  logic          clip;

  pdm_decimator #(
    .NBITS    (NB),
    .HALF_DIV (HD),
    .DECIM    (DC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pdm_din    (pdm_din),
    .mic_clk    (mic_clk),
    .dout       (dout),
    .dout_valid (dout_valid),
    .clip       (clip)
  );

  always #5 clk = ~clk;

  typedef enum int {PAT_ONES, PAT_ZEROS, PAT_ALT, PAT_SD256} pat_e;
  typedef struct {
    pat_e  pat;
    int    nsamp;
    int    exp_dout;
    int    tol;
    bit    exp_clip;
    string name;
  } vec_t;
  typedef struct {
    int dout;
    bit clip;
  } exp_t;

  exp_t   sb_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc = 0;

  int     h[HLEN];
  bit     hist[$];
  pat_e   cur_pat = PAT_ZEROS;
  int     bit_idx = 0;
  int     sd_acc = 0;
  bit     prev_mic = 1'b0;

  bit     mon_on = 1'b0;
  bit     valid_forbidden = 1'b0;
  bit     hold_bad = 1'b0;
  int     last_dout = 0;
  bit     last_clip = 1'b0;
  int     n_valid = 0;
  int     vals[$];
  longint vcyc[$];

  task automatic check(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic check_range(input string nm, input longint act, input longint req,
                             input longint tol);
    n_cmp++;
    if (act < req - tol || act > req + tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d +/- %0d", nm, act, req, tol);
    end
  endtask

  task automatic fail_event(input string nm, input longint act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0d, required none", nm, act);
  endtask

  // Reference: sinc3 == FIR whose taps are three cascaded length-DC boxcars.
  task automatic build_taps();
    int b2[2*DC-1];
    for (int i = 0; i < 2*DC-1; i++) b2[i] = 0;
    for (int a = 0; a < DC; a++)
      for (int b = 0; b < DC; b++) b2[a+b]++;
    for (int j = 0; j < HLEN; j++) h[j] = 0;
    for (int i = 0; i < 2*DC-1; i++)
      for (int c = 0; c < DC; c++) h[i+c] += b2[i];
  endtask

  task automatic model_push(input bit b);
    longint y;
    int     n;
    exp_t   e;
    hist.push_back(b);
    if (hist.size() % DC == 0) begin
      y = 0;
      n = hist.size() - 1;
      for (int j = 0; j < HLEN; j++)
        if (n - j >= 0 && hist[n-j]) y += h[j];
      if ((y >> 8) > 1023) begin
        e.dout = 1023;
        e.clip = 1'b1;
      end else begin
        e.dout = int'(y >> 8);
        e.clip = 1'b0;
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic drive_next();
    bit b;
    case (cur_pat)
      PAT_ONES:  b = 1'b1;
      PAT_ZEROS: b = 1'b0;
      PAT_ALT:   b = (bit_idx % 2 == 0);
      default: begin
        sd_acc += 256;
        if (sd_acc >= 1024) begin
          b = 1'b1;
          sd_acc -= 1024;
        end else begin
          b = 1'b0;
        end
      end
    endcase
    pdm_din = b;
    model_push(b);
    bit_idx++;
  endtask

  task automatic step();
    @(negedge clk);
    if (!prev_mic && mic_clk) drive_next();
    prev_mic = mic_clk;
  endtask

  task automatic restart_model(input pat_e p);
    cur_pat = p;
    bit_idx = 0;
    sd_acc  = 0;
    hist.delete();
    sb_q.delete();
    vals.delete();
    vcyc.delete();
    n_valid = 0;
    drive_next();
  endtask

  task automatic start_stream(input pat_e p);
    mon_on = 1'b0;
    rst    = 1'b1;
    en     = 1'b1;
    restart_model(p);
    repeat (3) @(negedge clk);
    rst       = 1'b0;
    prev_mic  = 1'b0;
    last_dout = 0;
    hold_bad  = 1'b0;
    mon_on    = 1'b1;
  endtask

  task automatic run_until(input int target);
    int budget;
    budget = (target - n_valid) * PERIOD + 3000;
    while (n_valid < target && budget > 0) begin
      step();
      budget--;
    end
    if (n_valid < target) fail_event("timeout_waiting_dout_valid", n_valid);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (mon_on) begin
      if (dout_valid) begin
        if (valid_forbidden) fail_event("valid_while_disabled", dout);
        check("dout_hold_between_strobes", hold_bad, 0);
        hold_bad = 1'b0;
        if (sb_q.size() == 0) begin
          fail_event("unexpected_dout_valid", dout);
        end else begin
          e = sb_q.pop_front();
          check("dout", dout, e.dout);
          check("clip", clip, e.clip);
        end
        last_dout = int'(dout);
        last_clip = clip;
        vals.push_back(int'(dout));
        vcyc.push_back(cyc);
        n_valid++;
      end else begin
        if (int'(dout) != last_dout) hold_bad = 1'b1;
        if (clip) fail_event("clip_without_valid", clip);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vt[4];
    int     ramp[4];
    int     guard;
    longint t_mark;
    bit     mic_seen;

    vt[0] = '{PAT_ONES,  4, 1023, 0, 1'b1, "ones"};
    vt[1] = '{PAT_ZEROS, 2, 0,    0, 1'b0, "zeros"};
    vt[2] = '{PAT_ALT,   4, 512,  0, 1'b0, "alternating"};
    vt[3] = '{PAT_SD256, 4, 256,  2, 1'b0, "sd256_loopback"};
    ramp  = '{178, 861, 1023, 1023};

    build_taps();

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_dout", dout, 0);
    check("reset_valid", dout_valid, 0);
    check("reset_clip", clip, 0);
    check("reset_mic_clk", mic_clk, 0);

    foreach (vt[k]) begin
      start_stream(vt[k].pat);
      run_until(vt[k].nsamp);
      if (vals.size() >= vt[k].nsamp) begin
        check_range({vt[k].name, "_settled_dout"}, vals[vt[k].nsamp-1], vt[k].exp_dout, vt[k].tol);
        check({vt[k].name, "_settled_clip"}, last_clip, vt[k].exp_clip);
        check({vt[k].name, "_strobe_period"}, vcyc[vt[k].nsamp-1] - vcyc[vt[k].nsamp-2], PERIOD);
      end
    end

    // Pause with the mic clock high, part-way into the second sample.
    start_stream(PAT_ALT);
    run_until(1);
    guard = 4 * PERIOD;
    while (!(bit_idx >= DC + 30 && mic_clk) && guard > 0) begin
      step();
      guard--;
    end
    en = 1'b0;
    valid_forbidden = 1'b1;
    @(negedge clk);
    check("pause_mic_low_within_1clk", mic_clk, 0);
    mic_seen = 1'b0;
    repeat (999) begin
      @(negedge clk);
      if (mic_clk) mic_seen = 1'b1;
    end
    check("pause_mic_stays_low", mic_seen, 0);
    en = 1'b1;
    valid_forbidden = 1'b0;
    @(negedge clk);
    prev_mic = mic_clk;
    run_until(2);
    if (vcyc.size() >= 2) check("pause_strobe_delay", vcyc[1] - vcyc[0], PERIOD + 1000);
    run_until(4);
    if (vals.size() >= 4) check("pause_settled_512", vals[3], 512);

    // Reset mid-sample with all-ones input, then the ramp must repeat.
    start_stream(PAT_ONES);
    run_until(1);
    guard = 4 * PERIOD;
    while (bit_idx < DC + 30 && guard > 0) begin
      step();
      guard--;
    end
    mon_on = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_dout", dout, 0);
    check("midrst_valid", dout_valid, 0);
    check("midrst_clip", clip, 0);
    check("midrst_mic_clk", mic_clk, 0);
    rst = 1'b0;
    restart_model(PAT_ONES);
    t_mark = cyc;
    @(negedge clk);
    check("midrst_valid_next_cycle", dout_valid, 0);
    prev_mic  = mic_clk;
    last_dout = 0;
    hold_bad  = 1'b0;
    mon_on    = 1'b1;
    run_until(4);
    if (vals.size() >= 4) begin
      check_range("midrst_first_valid_latency", vcyc[0] - t_mark, 2542, 1);
      for (int i = 0; i < 4; i++) check($sformatf("midrst_ramp_%0d", i), vals[i], ramp[i]);
      check("midrst_strobe_period", vcyc[3] - vcyc[2], PERIOD);
    end

    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
